// File: rtl/stepper_tracker.sv
// rtl/stepper_tracker.sv - glitch-filtered 4-wire stepper phase decoder with position, skip, release and idle tracking
// Optional error counters: define STEPPER_TRACKER_ERR_COUNT_EN.
module stepper_tracker #(
    parameter int POS_WIDTH     = 16,
    parameter int FILTER_CYCLES = 4,
    parameter int IDLE_CYCLES   = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 motor_phase_a,
    input  logic                 motor_phase_b,
    input  logic                 motor_phase_na,
    input  logic                 motor_phase_nb,
    input  logic                 clear_position,
    output logic [2:0]           step,
    output logic [POS_WIDTH-1:0] position,
    output logic                 direction,
    output logic                 step_pulse,
    output logic                 invalid,
    output logic                 skip_error,
    output logic                 released,
    output logic                 idle
`ifdef STEPPER_TRACKER_ERR_COUNT_EN
    ,
    output logic [7:0]           invalid_count,
    output logic [7:0]           skip_count
`endif
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

    typedef enum logic [1:0] {UNSYNC, TRACK, RELEASED} state_t;

    // Returns {legal, index}; 0000 and the three illegal codes report legal = 0.
    function automatic logic [3:0] decode(input logic [3:0] c);
        case (c)
            4'b1000: decode = 4'b1_000;
            4'b1100, 4'b1110: decode = 4'b1_001;
            4'b0100: decode = 4'b1_010;
            4'b0110, 4'b0111: decode = 4'b1_011;
            4'b0010: decode = 4'b1_100;
            4'b0011, 4'b1011: decode = 4'b1_101;
            4'b0001: decode = 4'b1_110;
            4'b1001, 4'b1101: decode = 4'b1_111;
            default: decode = 4'b0_000;
        endcase
    endfunction

    logic [3:0]           code_q, code_d;
    logic [FW-1:0]        stab_q, stab_d;
    logic                 accept_q, accept_d;
    state_t               state_q, state_d;
    logic [2:0]           step_q, step_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic                 pulse_q, pulse_d;
    logic                 inv_q, inv_d;
    logic                 skip_q, skip_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [3:0]           dec;
    logic [2:0]           delta;

    // Input capture and stability filter; acceptance fires once when the count first hits the limit.
    always_comb begin
        code_d = {motor_phase_a, motor_phase_b, motor_phase_na, motor_phase_nb};
        stab_d = stab_q;
        if (code_d != code_q) begin
            stab_d = '0;
        end else if (stab_q != FILT_MAX) begin
            stab_d = stab_q + FW'(1);
        end
        accept_d = (stab_d == FILT_MAX) && (stab_q != FILT_MAX);
    end

    // Tracking state machine acting on the accepted code; clear_position overrides any move.
    always_comb begin
        dec     = decode(code_q);
        delta   = dec[2:0] - step_q;
        state_d = state_q;
        step_d  = step_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;
        inv_d   = 1'b0;
        skip_d  = 1'b0;
        if (accept_q) begin
            case (state_q)
                UNSYNC: begin
                    if (dec[3]) begin
                        step_d  = dec[2:0];
                        state_d = TRACK;
                    end else if (code_q == 4'b0000) begin
                        state_d = RELEASED;
                    end else begin
                        inv_d = 1'b1;
                    end
                end
                TRACK: begin
                    if (dec[3]) begin
                        case (delta)
                            3'd0: ;
                            3'd1, 3'd2: begin
                                pos_d   = pos_q + POS_WIDTH'(delta);
                                dir_d   = 1'b1;
                                pulse_d = 1'b1;
                                step_d  = dec[2:0];
                            end
                            3'd6, 3'd7: begin
                                pos_d   = pos_q - POS_WIDTH'(4'd8 - {1'b0, delta});
                                dir_d   = 1'b0;
                                pulse_d = 1'b1;
                                step_d  = dec[2:0];
                            end
                            default: begin
                                skip_d = 1'b1;
                                step_d = dec[2:0];
                            end
                        endcase
                    end else if (code_q == 4'b0000) begin
                        state_d = RELEASED;
                    end else begin
                        inv_d = 1'b1;
                    end
                end
                RELEASED: begin
                    // The motor may have turned while unpowered, so resync without counting.
                    if (dec[3]) begin
                        step_d  = dec[2:0];
                        state_d = TRACK;
                    end else if (code_q != 4'b0000) begin
                        inv_d   = 1'b1;
                        state_d = UNSYNC;
                    end
                end
                default: state_d = UNSYNC;
            endcase
        end
        if (clear_position) begin
            pos_d = '0;
        end
        if (pulse_q) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + IW'(1);
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q     <= '0;
            stab_q     <= '0;
            accept_q   <= 1'b0;
            state_q    <= UNSYNC;
            step_q     <= '0;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            pulse_q    <= 1'b0;
            inv_q      <= 1'b0;
            skip_q     <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            code_q     <= code_d;
            stab_q     <= stab_d;
            accept_q   <= accept_d;
            state_q    <= state_d;
            step_q     <= step_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            pulse_q    <= pulse_d;
            inv_q      <= inv_d;
            skip_q     <= skip_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign step       = step_q;
    assign position   = pos_q;
    assign direction  = dir_q;
    assign step_pulse = pulse_q;
    assign invalid    = inv_q;
    assign skip_error = skip_q;
    assign released   = (state_q == RELEASED);
    assign idle       = (idle_cnt_q == IDLE_MAX);

`ifdef STEPPER_TRACKER_ERR_COUNT_EN
    logic [7:0] inv_cnt_q, inv_cnt_d;
    logic [7:0] skip_cnt_q, skip_cnt_d;

    // Saturating strobe counters, zeroed together with the position.
    always_comb begin
        inv_cnt_d  = inv_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (clear_position) begin
            inv_cnt_d  = '0;
            skip_cnt_d = '0;
        end else begin
            if (inv_q && inv_cnt_q != 8'hff) inv_cnt_d = inv_cnt_q + 8'd1;
            if (skip_q && skip_cnt_q != 8'hff) skip_cnt_d = skip_cnt_q + 8'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inv_cnt_q  <= '0;
            skip_cnt_q <= '0;
        end else begin
            inv_cnt_q  <= inv_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign invalid_count = inv_cnt_q;
    assign skip_count    = skip_cnt_q;
`endif

endmodule

// File: tb/tb_stepper_tracker.sv
// tb/tb_stepper_tracker.sv - scoreboard bench for stepper_tracker against a spec-level model
module tb_stepper_tracker;
    localparam int P    = 4;
    localparam int F    = 3;
    localparam int I    = 10;
    localparam int HOLD = F + 2;
    localparam int MASK = (1 << P) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] ph = 4'b0000;
    logic clear = 1'b0;
    logic [2:0] step;
    logic [P-1:0] position;
    logic direction, step_pulse, invalid, skip_error, released, idle;
`ifdef STEPPER_TRACKER_ERR_COUNT_EN
    logic [7:0] invalid_count, skip_count;
`endif

    stepper_tracker #(.POS_WIDTH(P), .FILTER_CYCLES(F), .IDLE_CYCLES(I)) dut (
        .clk(clk), .reset(rst_n),
        .motor_phase_a(ph[3]), .motor_phase_b(ph[2]),
        .motor_phase_na(ph[1]), .motor_phase_nb(ph[0]),
        .clear_position(clear),
        .step(step), .position(position), .direction(direction),
        .step_pulse(step_pulse), .invalid(invalid), .skip_error(skip_error),
        .released(released), .idle(idle)
`ifdef STEPPER_TRACKER_ERR_COUNT_EN
        , .invalid_count(invalid_count), .skip_count(skip_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit pulse; bit inv; bit skip;
        int step; int pos; int dir;
    } exp_t;
    exp_t sb[$];

    // Spec-level model: -1 illegal, -2 release, else half-step index.
    int dmap[16];
    int m_st;      // 0 unsync, 1 track, 2 released
    int m_step, m_pos, m_dir, m_inv_cnt, m_skip_cnt;
    logic [3:0] last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_step = 0; m_pos = 0; m_dir = 0; m_inv_cnt = 0; m_skip_cnt = 0;
    endtask

    task automatic model_accept(input logic [3:0] c, input bit clr);
        int idx, d;
        exp_t e;
        idx = dmap[c];
        e.pulse = 0; e.inv = 0; e.skip = 0;
        if (m_st == 0) begin
            if (idx >= 0) begin m_step = idx; m_st = 1; end
            else if (idx == -2) m_st = 2;
            else e.inv = 1;
        end else if (m_st == 1) begin
            if (idx >= 0) begin
                d = (idx - m_step + 8) % 8;
                if (d == 1 || d == 2) begin m_pos += d; m_dir = 1; e.pulse = 1; end
                else if (d == 6 || d == 7) begin m_pos -= 8 - d; m_dir = 0; e.pulse = 1; end
                else if (d != 0) e.skip = 1;
                m_step = idx;
            end else if (idx == -2) m_st = 2;
            else e.inv = 1;
        end else begin
            if (idx >= 0) begin m_step = idx; m_st = 1; end
            else if (idx == -1) begin e.inv = 1; m_st = 0; end
        end
        if (clr) begin m_pos = 0; m_inv_cnt = 0; m_skip_cnt = 0; end
        if (e.inv) m_inv_cnt = (m_inv_cnt < 255) ? m_inv_cnt + 1 : 255;
        if (e.skip) m_skip_cnt = (m_skip_cnt < 255) ? m_skip_cnt + 1 : 255;
        e.step = m_step; e.pos = m_pos & MASK; e.dir = m_dir;
        if (e.pulse || e.inv || e.skip) sb.push_back(e);
    endtask

    // Drive a code for `hold` clocks; with clr, clear_position lands on the update clock.
    task automatic apply(input logic [3:0] c, input int hold, input bit clr);
        ph = c;
        if (hold >= F + 1) model_accept(c, clr);
        if (clr) begin
            repeat (F + 1) @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            repeat (hold - F - 2) @(negedge clk);
        end else begin
            repeat (hold) @(negedge clk);
        end
        last = c;
        if (hold >= F + 2) begin
            chk("step_level", step, m_step);
            chk("pos_level", position, m_pos & MASK);
            chk("released_level", released, (m_st == 2) ? 1 : 0);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_pos = 0; m_inv_cnt = 0; m_skip_cnt = 0;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (step_pulse) begin ok = 1; break; end
        end
    endtask

    // Monitor: every strobe pops one expected event.
    always @(negedge clk) begin
        if (rst_n && (step_pulse || invalid || skip_error)) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {step_pulse, invalid, skip_error}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("strobes", {step_pulse, invalid, skip_error}, {e.pulse, e.inv, e.skip});
                chk("ev_step", step, e.step);
                chk("ev_pos", position, e.pos);
                chk("ev_dir", direction, e.dir);
            end
        end
    end

    initial begin
        bit ok;
        int n_inv;
        logic [3:0] c;
        int hold;
        bit clr;
        logic [3:0] ill [3];
        ill[0] = 4'b1111; ill[1] = 4'b1010; ill[2] = 4'b0101;
        for (int k = 0; k < 16; k++) dmap[k] = -1;
        dmap[4'b0000] = -2;
        dmap[4'b1000] = 0; dmap[4'b1100] = 1; dmap[4'b0100] = 2; dmap[4'b0110] = 3;
        dmap[4'b0010] = 4; dmap[4'b0011] = 5; dmap[4'b0001] = 6; dmap[4'b1001] = 7;
        dmap[4'b1110] = 1; dmap[4'b0111] = 3; dmap[4'b1011] = 5; dmap[4'b1101] = 7;
        model_reset();
        last = 4'b0000;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_outputs", {step, position, direction, step_pulse, invalid, skip_error, released, idle}, 0);
        rst_n = 1'b1;
        model_accept(4'b0000, 0);
        repeat (F + 3) @(negedge clk);
        chk("released_after_reset", released, 1);

        // Sync then half-step forward round trip
        apply(4'b1000, HOLD, 0);
        chk("sync_no_move", position, 0);
        apply(4'b1100, HOLD, 0); apply(4'b0100, HOLD, 0); apply(4'b0110, HOLD, 0);
        apply(4'b0010, HOLD, 0); apply(4'b0011, HOLD, 0); apply(4'b0001, HOLD, 0);
        apply(4'b1001, HOLD, 0); apply(4'b1000, HOLD, 0);
        chk("half_pos", position, 8);
        chk("half_dir", direction, 1);
        chk("half_step", step, 0);

        // Full-step reverse with wrap
        apply(4'b1100, HOLD, 0); apply(4'b0100, HOLD, 0); apply(4'b0110, HOLD, 0);
        pulse_clear();
        apply(4'b1100, HOLD, 0); apply(4'b1001, HOLD, 0); apply(4'b0011, HOLD, 0);
        chk("rev_pos", position, 10);
        chk("rev_dir", direction, 0);
        apply(4'b0110, HOLD, 0); apply(4'b1100, HOLD, 0);
        chk("wrap_pos", position, 6);

        // Short glitch while parked at 1000
        apply(4'b1000, HOLD, 0);
        apply(4'b0011, F - 1, 0);
        apply(4'b1000, HOLD, 0);
        chk("glitch_step", step, 0);

        // Skip then illegal, then a move proves tracking continues
        apply(4'b0010, HOLD, 0);
        chk("skip_step", step, 4);
        apply(4'b1111, HOLD, 0);
        apply(4'b0011, HOLD, 0);

        // Release, resync, clear coinciding with a move
        apply(4'b0000, HOLD + 3, 0);
        chk("released", released, 1);
        apply(4'b0100, HOLD, 0);
        chk("resync_step", step, 2);
        apply(4'b0110, HOLD, 1);
        chk("clr_move_pos", position, 0);
        chk("clr_move_step", step, 3);

        // Idle timing
        ph = 4'b0010; model_accept(4'b0010, 0); last = 4'b0010;
        wait_pulse(ok);
        chk("idle_pulse1_seen", ok, 1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 10) chk("idle_before", idle, 0);
            if (k == 11) chk("idle_rise", idle, 1);
        end
        ph = 4'b0011; model_accept(4'b0011, 0); last = 4'b0011;
        wait_pulse(ok);
        chk("idle_pulse2_seen", ok, 1);
        chk("idle_at_pulse", idle, 1);
        @(negedge clk);
        chk("idle_drop", idle, 0);
        repeat (HOLD) @(negedge clk);

        // Invalid burst
`ifdef STEPPER_TRACKER_ERR_COUNT_EN
        n_inv = 300;
`else
        n_inv = 20;
`endif
        for (int k = 0; k < n_inv; k++) apply((k % 2) ? 4'b1010 : 4'b1111, HOLD, 0);
`ifdef STEPPER_TRACKER_ERR_COUNT_EN
        chk("invalid_count_sat", invalid_count, 255);
        chk("skip_count", skip_count, m_skip_cnt);
        pulse_clear();
        @(negedge clk);
        chk("cnt_cleared", {invalid_count, skip_count}, 0);
`endif

        // Randomized phase activity
        for (int k = 0; k < 250; k++) begin
            do begin
                c = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) c = ill[$urandom_range(0, 2)];
            end while (c == last);
            clr = 0;
            if ($urandom_range(0, 3) == 0) hold = $urandom_range(1, F);
            else begin
                hold = $urandom_range(F + 2, F + 5);
                clr = ($urandom_range(0, 9) == 0);
            end
            apply(c, hold, clr);
        end
`ifdef STEPPER_TRACKER_ERR_COUNT_EN
        chk("rand_invalid_count", invalid_count, m_inv_cnt);
        chk("rand_skip_count", skip_count, m_skip_cnt);
`endif
        repeat (HOLD) @(negedge clk);

        // Mid-operation reset, first code afterwards is a sync
        rst_n = 1'b0;
        ph = 4'b1000;
        #1;
        chk("midrst_outputs", {step, position, direction, step_pulse, invalid, skip_error, released, idle}, 0);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_accept(4'b1000, 0);
        last = 4'b1000;
        repeat (HOLD) @(negedge clk);
        chk("post_rst_sync_pos", position, 0);
        apply(4'b1100, HOLD, 0);
        chk("post_rst_move", position, 1);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stepper_tracker.md
Name: stepper_tracker

Overview:
Parametrised successor to the single-channel phase decoder. Decodes the 4-wire stepper drive into a half-step index, as the existing decoder does, and adds:
- glitch filtering on the phase inputs;
- direction detection and a signed half-step position accumulator;
- full-step/half-step tolerance, skip detection and de-energise (release) handling;
- an idle timeout.
Sits between the print-mechanism phase inputs and the paper-feed/carriage analysis logic.

Parameters:
POS_WIDTH, 16, width of signed position counter in half-steps (>=4)
FILTER_CYCLES, 4, consecutive clocks a phase code must be stable before acceptance (>=1)
IDLE_CYCLES, 100000, clocks without an accepted move before idle asserts (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
motor_phase_a  input  1  phase A drive
motor_phase_b  input  1  phase B drive
motor_phase_na  input  1  phase /A drive
motor_phase_nb  input  1  phase /B drive
clear_position  input  1  synchronous zero of position
step  output  3  current half-step index 0..7
position  output  POS_WIDTH  signed accumulated half-steps, two's complement
direction  output  1  1 = last move forward (increasing index), 0 = reverse
step_pulse  output  1  one-clock strobe per accepted move
invalid  output  1  one-clock strobe per accepted illegal code
skip_error  output  1  one-clock strobe when a move of 3, 4 or 5 half-steps is seen
released  output  1  level; motor de-energised (code 0000)
idle  output  1  level; no accepted move for IDLE_CYCLES clocks

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset values: all outputs 0. Internal FSM state = UNSYNC. Filter and idle counters = 0.
- Inputs are registered once as code = {a,b,na,nb}. A stability counter clears on any code change and otherwise saturates at FILTER_CYCLES.
- Acceptance: a code is accepted exactly once, on the clock its counter reaches FILTER_CYCLES. Outputs update on the following clock, FILTER_CYCLES+1 clocks after the input settles. Shorter glitches have no effect.
- Decode map, code to index:
  - 1000→0, 1100→1, 0100→2, 0110→3, 0010→4, 0011→5, 0001→6, 1001→7.
  - Inter-step codes 1110→1, 0111→3, 1011→5, 1101→7.
  - 0000 = release.
  - All other codes are illegal.
- FSM states: UNSYNC, TRACK, RELEASED.
- UNSYNC:
  - valid code: load step; no position change, no step_pulse; go to TRACK.
  - 0000: go to RELEASED.
  - illegal code: invalid strobe; stay.
- TRACK, valid code: delta = (new − step) mod 8, 3-bit.
  - delta 0: nothing.
  - delta 1 or 2: position += delta, direction = 1, step_pulse.
  - delta 7 or 6: position −= (8 − delta), direction = 0, step_pulse.
  - delta 3, 4 or 5: skip_error strobe; step loads; position and direction unchanged; no step_pulse.
- TRACK, illegal code: invalid strobe; step and position held; stay in TRACK.
- TRACK, 0000: go to RELEASED; step held.
- RELEASED:
  - released = 1.
  - Next valid code loads step with no position change (motor may have moved unpowered), then go to TRACK.
  - Illegal code: invalid strobe; go to UNSYNC.
- position wraps modulo 2^POS_WIDTH, with no saturation.
- clear_position sets position to 0 in any state. When it coincides with a move, clear wins: position = 0, while step, direction and step_pulse still update.
- Idle counter:
  - clears on every step_pulse;
  - otherwise increments, saturating at IDLE_CYCLES;
  - idle = (count == IDLE_CYCLES);
  - idle deasserts on the clock after a step_pulse.
- Reset asserted mid-operation returns to the reset values immediately; the first code after reset is a sync, not a move.

Optional Feature:
Macro: STEPPER_TRACKER_ERR_COUNT_EN.
- Defined: adds outputs invalid_count[7:0] and skip_count[7:0].
  - Each counts its own strobe and saturates at 255.
  - Both zeroed by reset and by clear_position.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Half-step sequence 0→1→…→7→0 after sync at 1000, each code held FILTER_CYCLES+2 clocks -> 8 step_pulses, position = 8, direction = 1, step = 0.
- Full-step reverse 0110→1100→1001→0011 -> three moves of −2, position = −6, direction = 0. With POS_WIDTH=4, continue reversing until position wraps from −8 to +6.
- Glitch of FILTER_CYCLES−1 clocks to 0011 while tracking at 1000 -> no step_pulse, no invalid, step stays 0.
- Jump 1000→0010 (delta 4) -> skip_error one clock, step = 4, position unchanged. Then illegal 1111 -> invalid one clock, state stays TRACK.
- 0000 held, then 0100 -> released = 1, then step = 2 with position unchanged and no step_pulse. clear_position pulsed together with a +1 move -> position = 0, step_pulse = 1.
- IDLE_CYCLES=10, no moves -> idle rises exactly 10 clocks after the last step_pulse and drops one clock after the next. With ERR_COUNT enabled, 300 invalid strobes -> invalid_count = 255.
